emit2_responder: RTL and testbench

//   Responder end of the count2/count_ACK2 four-phase handshake used between emitter stages.
//   - When the downstream emitter raises count2, this stage drives out2 high for a

---
 rtl/emit2_responder_if.sv | 18 +
 rtl/emit2_responder.sv | 89 ++++++++
 tb/tb_emit2_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/emit2_responder_if.sv
// emit2_responder_if: dispense-controller and handshake signals for the emit2 responder.
// The abort2 signal exists only when EMIT2_ABORT_EN is defined.
interface emit2_responder_if #(parameter int CNT_W = 8);
    logic             load2;
    logic [CNT_W-1:0] load_val;
    logic             count2;
    logic             count_ACK2;
    logic             out2;
    logic             busy;
`ifdef EMIT2_ABORT_EN
    logic             abort2;
    modport master (output load2, load_val, count2, input count_ACK2, out2, busy, abort2);
    modport slave  (input load2, load_val, count2, output count_ACK2, out2, busy, abort2);
`else
    modport master (output load2, load_val, count2, input count_ACK2, out2, busy);
    modport slave  (input load2, load_val, count2, output count_ACK2, out2, busy);
`endif
endinterface

// File: rtl/emit2_responder.sv
// emit2_responder: count2/count_ACK2 four-phase responder driving a programmable out2 dose.
// Optional EMIT2_ABORT_EN: count2 low during RUN aborts the dose and pulses abort2.
module emit2_responder #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_CNT = 10
) (
    input logic             clk,
    input logic             RESET,
    emit2_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] reload, reload_n, cnt, cnt_n, len;
    logic             out2_q, out2_n, ack_q, ack_n;
`ifdef EMIT2_ABORT_EN
    logic             abort_q, abort_n;
`endif
    // a load in the same cycle as the request supplies this request's length
    assign len = bus.load2 ? bus.load_val : reload;
    always_comb begin
        state_n  = state;
        reload_n = reload;
        cnt_n    = cnt;
        out2_n   = out2_q;
        ack_n    = ack_q;
`ifdef EMIT2_ABORT_EN
        abort_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                reload_n = bus.load2 ? bus.load_val : reload;
                if (bus.count2) begin
                    cnt_n   = len;
                    out2_n  = len != '0;
                    state_n = len != '0 ? RUN : ACK;
                end
            end
            RUN: begin
                cnt_n = cnt != '0 ? cnt - 1'b1 : cnt;
                if (cnt <= CNT_W'(1)) begin
                    out2_n  = 1'b0;
                    ack_n   = 1'b1;
                    state_n = ACK;
                end
`ifdef EMIT2_ABORT_EN
                if (!bus.count2) begin
                    out2_n  = 1'b0;
                    ack_n   = 1'b0;
                    cnt_n   = '0;
                    abort_n = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            ACK: begin
                ack_n   = bus.count2;
                state_n = bus.count2 ? ACK : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (RESET) begin
            state  <= IDLE;
            reload <= CNT_W'(DEFAULT_CNT);
            cnt    <= '0;
            out2_q <= 1'b0;
            ack_q  <= 1'b0;
`ifdef EMIT2_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            reload <= reload_n;
            cnt    <= cnt_n;
            out2_q <= out2_n;
            ack_q  <= ack_n;
`ifdef EMIT2_ABORT_EN
            abort_q <= abort_n;
`endif
        end
    end
    assign bus.out2       = out2_q;
    assign bus.count_ACK2 = ack_q;
    assign bus.busy       = state != IDLE;
`ifdef EMIT2_ABORT_EN
    assign bus.abort2     = abort_q;
`endif
endmodule

// File: tb/tb_emit2_responder.sv
// tb_emit2_responder: randomized request/load traffic checked against a closed-form
// per-transaction timeline model of the emit2 responder.
module tb_emit2_responder;
    logic clk = 1'b0;
    logic RESET = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   ref_reload = 10;
`ifdef EMIT2_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    emit2_responder_if #(.CNT_W(8)) bus();
    emit2_responder #(.CNT_W(8), .DEFAULT_CNT(10)) dut (.clk(clk), .RESET(RESET), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_out2"}, bus.out2, 0);
        check({name, "_ack"}, bus.count_ACK2, 0);
        check({name, "_busy"}, bus.busy, 0);
`ifdef EMIT2_ABORT_EN
        check({name, "_abort"}, bus.abort2, 0);
`endif
    endtask

    task automatic load(input int v);
        bus.load2 = 1'b1;
        bus.load_val = 8'(v);
        step();
        bus.load2 = 1'b0;
        ref_reload = v;
        check_idle("load");
    endtask

    // Request sampled at edge t; observation k is taken just after edge t+k.
    // count2 stays high for edges t+1..t+d, then low.
    task automatic req(input string name, input int d, input bit byp, input int v);
        int  n, l;
        bit  ab;
        bus.count2 = 1'b1;
        if (byp) begin
            bus.load2 = 1'b1;
            bus.load_val = 8'(v);
            ref_reload = v;
        end
        n  = ref_reload;
        ab = ABORT_EN && n > 0 && d < n;
        l  = ab ? d + 1 : ((d > n ? d : n) + 1);
        step();
        bus.load2 = 1'b0;
        for (int k = 0; k <= l; k++) begin
            check($sformatf("%s_out2_k%0d", name, k), bus.out2, ab ? (k <= d) : (k < n));
            check($sformatf("%s_ack_k%0d", name, k), bus.count_ACK2,
                  !ab && ((n > 0 && k == n) || (k > n && k <= d)));
            check($sformatf("%s_busy_k%0d", name, k), bus.busy, k < l);
            check($sformatf("%s_excl_k%0d", name, k), bus.out2 & bus.count_ACK2, 0);
`ifdef EMIT2_ABORT_EN
            check($sformatf("%s_abort_k%0d", name, k), bus.abort2, ab && k == l);
`endif
            bus.count2 = (k + 1 <= d);
            bus.load2 = (k + 1 < l) && ($urandom_range(0, 2) == 0);
            bus.load_val = 8'($urandom);
            if (k < l) step();
        end
        bus.load2 = 1'b0;
    endtask

    initial begin
        bus.load2 = 1'b0;
        bus.load_val = '0;
        bus.count2 = 1'b0;
        step();
        step();
        check_idle("reset");
        RESET = 1'b0;
        step();
        check_idle("post_reset");
        req("dflt", 12, 1'b0, 0);
        load(3);
        req("len3", 5, 1'b0, 0);
        load(0);
        req("zero", 3, 1'b0, 0);
        req("bypass5", 7, 1'b1, 5);
        req("again5", 6, 1'b0, 0);
        // reset during the 4th out2 cycle of a 10-cycle dose
        load(10);
        bus.count2 = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pre_rst_out2_k%0d", k), bus.out2, 1);
            if (k < 3) step();
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        bus.count2 = 1'b0;
        check_idle("mid_rst");
        ref_reload = 10;
        step();
        req("after_rst", 11, 1'b0, 0);
        load(5);
        req("drop", 1, 1'b0, 0);
        req("drop0", 0, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) load($urandom_range(0, 12));
            req("rnd", $urandom_range(0, 14), $urandom_range(0, 3) == 0, $urandom_range(0, 12));
            if ($urandom_range(0, 1) == 0) step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
